// File: rtl/projection_scheduler.sv
// Frame sequencer for the 3D->2D projection pipeline: freezes the camera pose per frame,
// issues NUM_TRIS credit-gated triangles, then retires results before pulsing frame_done.
module projection_scheduler #(
  parameter int NUM_TRIS   = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int IDXW       = (NUM_TRIS > 1) ? $clog2(NUM_TRIS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_start,
  input  logic [29:0]     camera_loc_in,
  output logic [29:0]     camera_loc_out,
  output logic            issue_valid,
  output logic [IDXW-1:0] issue_idx,
  input  logic            result_valid,
  input  logic            credit_return,
  output logic [7:0]      credits,
  output logic            busy,
  output logic            frame_done,
  output logic [15:0]     frame_count,
  output logic [7:0]      missed_frames,
  output logic            protocol_err
);
  localparam int              CNTW = $clog2(NUM_TRIS + 1);
  localparam logic [7:0]      FULL = 8'(FIFO_DEPTH);
  localparam logic [CNTW-1:0] LAST = CNTW'(NUM_TRIS - 1);
  localparam logic [CNTW-1:0] NTRI = CNTW'(NUM_TRIS);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] issued_q, issued_d;
  logic [7:0]      in_flight_q, in_flight_d;
  logic [29:0]     camera_q, camera_d;
  logic            issue_valid_q, issue_valid_d;
  logic [IDXW-1:0] issue_idx_q, issue_idx_d;
  logic [7:0]      credits_q, credits_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;
  logic [15:0]     frame_count_q, frame_count_d;
  logic [7:0]      missed_q, missed_d;
  logic            perr_q, perr_d;
  logic            issue_now, credit_ok, result_ok;

  always_comb begin
    state_d       = state_q;
    issued_d      = issued_q;
    camera_d      = camera_q;
    issue_valid_d = 1'b0;
    issue_idx_d   = issue_idx_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    missed_d      = missed_q;

    issue_now = (state_q == ISSUE) && (credits_q != 8'd0) && (issued_q < NTRI);
    // Returns at a full FIFO and results with nothing in flight are dropped, not counted.
    credit_ok = credit_return && (credits_q != FULL);
    result_ok = result_valid && (in_flight_q != 8'd0);

    credits_d = credits_q;
    if (issue_now && !credit_ok)      credits_d = credits_q - 8'd1;
    else if (!issue_now && credit_ok) credits_d = credits_q + 8'd1;

    in_flight_d = in_flight_q;
    if (issue_now && !result_ok)      in_flight_d = in_flight_q + 8'd1;
    else if (!issue_now && result_ok) in_flight_d = in_flight_q - 8'd1;

    perr_d = perr_q | (credit_return && !credit_ok) | (result_valid && !result_ok);

    if (frame_start && (state_q != IDLE) && (missed_q != 8'hFF)) missed_d = missed_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          camera_d = camera_loc_in;
          issued_d = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_now) begin
          issue_valid_d = 1'b1;
          issue_idx_d   = IDXW'(issued_q);
          issued_d      = issued_q + 1'b1;
          if (issued_q == LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // frame_done is raised on entry to DONE so it lands two cycles after the last result.
        if (in_flight_q == 8'd0) begin
          state_d       = DONE;
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      issued_q      <= '0;
      in_flight_q   <= 8'd0;
      camera_q      <= 30'd0;
      issue_valid_q <= 1'b0;
      issue_idx_q   <= '0;
      credits_q     <= FULL;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 16'd0;
      missed_q      <= 8'd0;
      perr_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      issued_q      <= issued_d;
      in_flight_q   <= in_flight_d;
      camera_q      <= camera_d;
      issue_valid_q <= issue_valid_d;
      issue_idx_q   <= issue_idx_d;
      credits_q     <= credits_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      missed_q      <= missed_d;
      perr_q        <= perr_d;
    end
  end

  assign camera_loc_out = camera_q;
  assign issue_valid    = issue_valid_q;
  assign issue_idx      = issue_idx_q;
  assign credits        = credits_q;
  assign busy           = busy_q;
  assign frame_done     = frame_done_q;
  assign frame_count    = frame_count_q;
  assign missed_frames  = missed_q;
  assign protocol_err   = perr_q;
endmodule

// File: tb/tb_projection_scheduler.sv
// Bench for projection_scheduler: cycle table for the basic frame, directed corner sequences,
// and randomized frames checked against a credit/ordering model.
module tb_projection_scheduler;
  localparam int NT = 4;
  localparam int FD = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        frame_start, result_valid, credit_return;
  logic [29:0] camera_loc_in, camera_loc_out;
  logic        issue_valid, busy, frame_done, protocol_err;
  logic [1:0]  issue_idx;
  logic [7:0]  credits, missed_frames;
  logic [15:0] frame_count;

  logic        fs2, rv2, cr2;
  logic [29:0] cam_out2;
  logic        iv2, busy2, fd2, perr2;
  logic [1:0]  idx2;
  logic [7:0]  credits2, missed2;
  logic [15:0] count2;

  projection_scheduler #(.NUM_TRIS(NT), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .camera_loc_in(camera_loc_in),
    .camera_loc_out(camera_loc_out), .issue_valid(issue_valid), .issue_idx(issue_idx),
    .result_valid(result_valid), .credit_return(credit_return), .credits(credits),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
    .missed_frames(missed_frames), .protocol_err(protocol_err)
  );

  projection_scheduler #(.NUM_TRIS(NT), .FIFO_DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .frame_start(fs2), .camera_loc_in(30'h0000_0042),
    .camera_loc_out(cam_out2), .issue_valid(iv2), .issue_idx(idx2),
    .result_valid(rv2), .credit_return(cr2), .credits(credits2),
    .busy(busy2), .frame_done(fd2), .frame_count(count2),
    .missed_frames(missed2), .protocol_err(perr2)
  );

  typedef struct {
    logic       fs, rv, cr;
    logic       iv;
    logic [1:0] idx;
    logic [7:0] cred;
    logic       busy, fd;
  } vec_t;

  vec_t        tv[17];
  int          n_pass = 0, n_total = 0;
  int          n_iss = 0, n_ret = 0;
  logic [1:0]  exp_q[$];
  int          m_credits, m_missed, m_frames, pending, nc, last_rv, iss2;
  bit          done, cr_prev;
  logic [29:0] m_cam;
  int          t3_cred[13] = '{16, 16, 15, 15, 15, 14, 14, 14, 14, 14, 14, 15, 16};

  function automatic vec_t mk(int fs, int rv, int cr, int iv, int idx, int cred, int bsy, int fd);
    vec_t v;
    v.fs = 1'(fs); v.rv = 1'(rv); v.cr = 1'(cr); v.iv = 1'(iv);
    v.idx = 2'(idx); v.cred = 8'(cred); v.busy = 1'(bsy); v.fd = 1'(fd);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (issue_valid) n_iss++;
  endtask

  task automatic do_reset();
    rst = 1'b1; frame_start = 1'b0; result_valid = 1'b0; credit_return = 1'b0;
    fs2 = 1'b0; rv2 = 1'b0; cr2 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_ret = n_iss;
  endtask

  // Returns one result per outstanding issue until frame_done, then steps into IDLE.
  task automatic run_to_done(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      result_valid = (n_iss > n_ret);
      if (result_valid) n_ret++;
      tick();
      if (frame_done) seen = 1'b1;
    end
    result_valid = 1'b0;
    check({name, "_frame_done_seen"}, seen, 1);
    tick();
  endtask

  initial begin
    camera_loc_in = 30'd0;
    do_reset();
    check("rst_issue_valid", issue_valid, 0);
    check("rst_issue_idx", issue_idx, 0);
    check("rst_camera", camera_loc_out, 0);
    check("rst_credits", credits, FD);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_missed", missed_frames, 0);
    check("rst_perr", protocol_err, 0);

    // Basic frame: issues in cycles 2-5, results 10-13, frame_done in cycle 15.
    tv[0]  = mk(1, 0, 0, 0, 0, 16, 0, 0);
    tv[1]  = mk(0, 0, 0, 0, 0, 16, 1, 0);
    tv[2]  = mk(0, 0, 0, 1, 0, 15, 1, 0);
    tv[3]  = mk(0, 0, 0, 1, 1, 14, 1, 0);
    tv[4]  = mk(0, 0, 0, 1, 2, 13, 1, 0);
    tv[5]  = mk(0, 0, 0, 1, 3, 12, 1, 0);
    tv[6]  = mk(0, 0, 0, 0, 0, 12, 1, 0);
    tv[7]  = mk(0, 0, 0, 0, 0, 12, 1, 0);
    tv[8]  = mk(0, 0, 0, 0, 0, 12, 1, 0);
    tv[9]  = mk(0, 0, 0, 0, 0, 12, 1, 0);
    tv[10] = mk(0, 1, 1, 0, 0, 12, 1, 0);
    tv[11] = mk(0, 1, 1, 0, 0, 13, 1, 0);
    tv[12] = mk(0, 1, 1, 0, 0, 14, 1, 0);
    tv[13] = mk(0, 1, 1, 0, 0, 15, 1, 0);
    tv[14] = mk(0, 0, 0, 0, 0, 16, 1, 0);
    tv[15] = mk(0, 0, 0, 0, 0, 16, 1, 1);
    tv[16] = mk(0, 0, 0, 0, 0, 16, 0, 0);
    for (int k = 0; k < 17; k++) begin
      frame_start = tv[k].fs; result_valid = tv[k].rv; credit_return = tv[k].cr;
      camera_loc_in = (k == 0) ? 30'h1234_5678 : 30'($urandom);
      check($sformatf("t1_issue_valid_c%0d", k), issue_valid, tv[k].iv);
      if (tv[k].iv) check($sformatf("t1_issue_idx_c%0d", k), issue_idx, tv[k].idx);
      check($sformatf("t1_credits_c%0d", k), credits, tv[k].cred);
      check($sformatf("t1_busy_c%0d", k), busy, tv[k].busy);
      check($sformatf("t1_frame_done_c%0d", k), frame_done, tv[k].fd);
      if (k >= 1) check($sformatf("t1_camera_c%0d", k), camera_loc_out, 30'h1234_5678);
      tick();
    end
    frame_start = 1'b0; result_valid = 1'b0; credit_return = 1'b0;
    n_ret = n_iss;
    check("t1_frame_count", frame_count, 1);
    check("t1_perr", protocol_err, 0);

    // Credit return and result retire on the same edges as issues.
    for (int k = 0; k < 13; k++) begin
      frame_start   = (k == 0);
      camera_loc_in = (k == 0) ? 30'h0ABC_DEF0 : 30'($urandom);
      credit_return = (k == 2 || k == 3 || k == 10 || k == 11);
      result_valid  = (k == 2 || k == 3 || k == 6 || k == 7);
      check($sformatf("t3_credits_c%0d", k), credits, t3_cred[k]);
      check($sformatf("t3_issue_valid_c%0d", k), issue_valid, (k >= 2 && k <= 5));
      check($sformatf("t3_frame_done_c%0d", k), frame_done, (k == 9));
      if (k >= 1) check($sformatf("t3_camera_c%0d", k), camera_loc_out, 30'h0ABC_DEF0);
      tick();
    end
    frame_start = 1'b0; result_valid = 1'b0; credit_return = 1'b0;
    n_ret = n_iss;
    check("t3_frame_count", frame_count, 2);
    check("t3_perr", protocol_err, 0);

    // Starvation on a two-entry FIFO.
    iss2 = 0;
    for (int k = 0; k < 37; k++) begin
      fs2 = (k == 0);
      cr2 = (k == 20 || k == 23);
      rv2 = (k >= 30 && k <= 33);
      if (k <= 20 && iv2) iss2++;
      if (k == 20) begin
        check("t2_issues_before_return", iss2, 2);
        check("t2_credits_starved", credits2, 0);
        check("t2_busy_starved", busy2, 1);
      end
      if (k == 21) check("t2_no_issue_c21", iv2, 0);
      if (k == 22) begin
        check("t2_issue_c22", iv2, 1);
        check("t2_idx_c22", idx2, 2);
        check("t2_credits_c22", credits2, 0);
      end
      if (k == 25) begin
        check("t2_issue_c25", iv2, 1);
        check("t2_idx_c25", idx2, 3);
      end
      if (k == 35) check("t2_frame_done_c35", fd2, 1);
      if (k == 36) begin
        check("t2_frame_done_c36", fd2, 0);
        check("t2_frame_count", count2, 1);
        check("t2_busy_idle", busy2, 0);
      end
      tick();
    end
    fs2 = 1'b0; cr2 = 1'b0; rv2 = 1'b0;

    // Randomized frames against the credit/ordering model.
    m_credits = FD; m_missed = 0; m_frames = 2;
    for (int f = 0; f < 12; f++) begin
      check($sformatf("rnd%0d_idle", f), busy, 0);
      m_cam = 30'($urandom);
      camera_loc_in = m_cam; frame_start = 1'b1; credit_return = 1'b0; result_valid = 1'b0;
      exp_q.delete();
      for (int j = 0; j < NT; j++) exp_q.push_back(2'(j));
      m_frames++; pending = 0; done = 1'b0; last_rv = -10;
      for (int c = 0; c < 400 && !done; c++) begin
        cr_prev = credit_return;
        tick();
        nc = m_credits + ((cr_prev && m_credits < FD) ? 1 : 0);
        if (issue_valid) begin
          check("rnd_issue_needs_credit", (m_credits > 0), 1);
          nc--; pending++;
          if (exp_q.size() > 0) check($sformatf("rnd%0d_idx", f), issue_idx, exp_q.pop_front());
          else check($sformatf("rnd%0d_extra_issue", f), issue_valid, 0);
        end
        m_credits = nc;
        check($sformatf("rnd%0d_credits", f), credits, m_credits);
        check($sformatf("rnd%0d_camera", f), camera_loc_out, m_cam);
        check($sformatf("rnd%0d_missed", f), missed_frames, m_missed);
        check($sformatf("rnd%0d_busy", f), busy, 1);
        if (frame_done) begin
          done = 1'b1;
          check($sformatf("rnd%0d_frame_count", f), frame_count, m_frames);
          check($sformatf("rnd%0d_all_issued", f), exp_q.size(), 0);
          check($sformatf("rnd%0d_done_latency", f), (c + 1) - last_rv, 2);
        end
        camera_loc_in = 30'($urandom);
        frame_start = !done && ($urandom_range(0, 7) == 0);
        if (frame_start && m_missed < 255) m_missed++;
        credit_return = !done && (m_credits < FD) && ($urandom_range(0, 5) == 0);
        result_valid = (pending > 0) && ($urandom_range(0, 1) == 1);
        if (result_valid) begin
          pending--;
          last_rv = c + 1;
        end
      end
      check($sformatf("rnd%0d_completed", f), done, 1);
      frame_start = 1'b0; credit_return = 1'b0; result_valid = 1'b0;
      tick();
    end
    n_ret = n_iss;
    check("rnd_perr", protocol_err, 0);
    while (m_credits < FD) begin
      credit_return = 1'b1; tick(); m_credits++;
    end
    credit_return = 1'b0;
    tick();
    check("rnd_credits_restored", credits, FD);

    // Reset in the middle of issue, then a clean frame.
    camera_loc_in = 30'h0555_AAAA; frame_start = 1'b1; tick(); frame_start = 1'b0;
    tick();
    check("t5_issue_c2", issue_valid, 1);
    tick();
    check("t5_issue_c3", issue_valid, 1);
    check("t5_idx_c3", issue_idx, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t5_issue_after_rst", issue_valid, 0);
    check("t5_busy_after_rst", busy, 0);
    check("t5_credits_after_rst", credits, FD);
    check("t5_camera_after_rst", camera_loc_out, 0);
    n_ret = n_iss;
    camera_loc_in = 30'h0666_1111; frame_start = 1'b1; tick(); frame_start = 1'b0;
    tick();
    for (int j = 0; j < NT; j++) begin
      check($sformatf("t5_reissue_valid_%0d", j), issue_valid, 1);
      check($sformatf("t5_reissue_idx_%0d", j), issue_idx, j);
      tick();
    end
    run_to_done("t5");
    check("t5_frame_count", frame_count, 1);

    // Overrun: one ignored request mid-issue, then 300 while draining.
    camera_loc_in = 30'h0111_1111; frame_start = 1'b1; tick(); frame_start = 1'b0;
    tick(); tick();
    camera_loc_in = 30'h0222_2222; frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("t4_missed_one", missed_frames, 1);
    check("t4_camera_held", camera_loc_out, 30'h0111_1111);
    run_to_done("t4a");
    check("t4_frame_count", frame_count, 2);
    camera_loc_in = 30'h0333_3333; frame_start = 1'b1; tick();
    for (int j = 0; j < 300; j++) begin
      camera_loc_in = 30'($urandom);
      tick();
    end
    frame_start = 1'b0;
    check("t4_missed_saturated", missed_frames, 255);
    check("t4_camera_held_long", camera_loc_out, 30'h0333_3333);
    check("t4_busy_long", busy, 1);
    run_to_done("t4b");
    check("t4_missed_still_sat", missed_frames, 255);

    // Spurious result in IDLE, then return at a full FIFO.
    result_valid = 1'b1; tick(); result_valid = 1'b0;
    check("t6_perr_set", protocol_err, 1);
    repeat (5) tick();
    check("t6_perr_sticky", protocol_err, 1);
    check("t6_busy", busy, 0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    run_to_done("t6");
    check("t6_perr_after_frame", protocol_err, 1);
    do_reset();
    check("t6_perr_cleared", protocol_err, 0);
    credit_return = 1'b1; tick(); credit_return = 1'b0;
    check("t6_perr_full_return", protocol_err, 1);
    check("t6_credits_capped", credits, FD);
    do_reset();
    check("t6_perr_cleared2", protocol_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
